// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p fetch path.
// Holds the fetch request controller state encoding and address helpers.
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRANCH_WAIT
    } fetch_ctrl_state_e;

    localparam logic [31:0] FETCH_STRIDE = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/cv32e40p_fetch_req_ctrl.sv
// OBI instruction-fetch request sequencer in front of the prefetch FIFO.
// Issues sequential word fetches, redirects, and drops stale responses.
module cv32e40p_fetch_req_ctrl
    import cv32e40p_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_i,
    input  logic                          branch_i,
    input  logic [31:0]                   branch_addr_i,
    input  logic                          hwlp_jump_i,
    input  logic [31:0]                   hwlp_target_i,
    input  logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_i,
    input  logic                          instr_gnt_i,
    input  logic                          instr_rvalid_i,
    output logic                          instr_req_o,
    output logic [31:0]                   instr_addr_o,
    output logic                          fifo_push_o,
    output logic                          fifo_flush_o,
    output logic                          busy_o
);

    localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);

    fetch_ctrl_state_e state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [OCW-1:0]    out_cnt_q, out_cnt_d;
    logic [OCW-1:0]    flush_cnt_q, flush_cnt_d;
    logic              pend_q, pend_d;

    logic              redirect;
    logic [31:0]       tgt;
    logic              credit_ok;
    logic              old_gnt;
    logic              gnt_acc;
    logic              drop;

    assign redirect  = branch_i | hwlp_jump_i;
    assign tgt       = word_align(branch_i ? branch_addr_i : hwlp_target_i);
    assign credit_ok = (32'(out_cnt_q) < MAX_OUTSTANDING) &&
                       (32'(out_cnt_q) + 32'(fifo_cnt_i) < FIFO_DEPTH);

    assign fifo_flush_o = redirect;
    assign fifo_push_o  = instr_rvalid_i & (flush_cnt_q == '0) & ~redirect;
    assign busy_o       = instr_req_o | (out_cnt_q != '0);

    // Next-state, request/address generation and counter updates
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        tgt_d        = tgt_q;
        instr_req_o  = 1'b0;
        instr_addr_o = addr_q;
        old_gnt      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) state_d = RUN;
                if (redirect) addr_d = tgt;
            end
            RUN: begin
                instr_req_o = pend_q | (req_i & credit_ok);
                if (!pend_q && redirect) instr_addr_o = tgt;
                if (redirect) begin
                    if (pend_q) begin
                        old_gnt = instr_gnt_i;
                        if (instr_gnt_i) begin
                            addr_d = tgt;
                        end else begin
                            tgt_d   = tgt;
                            state_d = BRANCH_WAIT;
                        end
                    end else if (instr_req_o && instr_gnt_i) begin
                        addr_d = tgt + FETCH_STRIDE;
                    end else begin
                        addr_d = tgt;
                    end
                end else if (instr_req_o && instr_gnt_i) begin
                    addr_d = addr_q + FETCH_STRIDE;
                end
                if (!req_i && !pend_q) state_d = IDLE;
            end
            BRANCH_WAIT: begin
                instr_req_o = 1'b1;
                old_gnt     = instr_gnt_i;
                if (redirect) tgt_d = tgt;
                if (instr_gnt_i) begin
                    addr_d  = redirect ? tgt : tgt_q;
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_acc   = instr_req_o & instr_gnt_i;
        pend_d    = instr_req_o & ~instr_gnt_i;
        out_cnt_d = out_cnt_q + OCW'(gnt_acc) - OCW'(instr_rvalid_i);
        drop      = instr_rvalid_i & (flush_cnt_q != '0);
        if (redirect) begin
            flush_cnt_d = out_cnt_q + OCW'(old_gnt) - OCW'(instr_rvalid_i);
        end else begin
            flush_cnt_d = flush_cnt_q + OCW'(old_gnt) - OCW'(drop);
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            tgt_q       <= '0;
            out_cnt_q   <= '0;
            flush_cnt_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            tgt_q       <= tgt_d;
            out_cnt_q   <= out_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
        end
    end

    // A response can only answer a granted transaction
    a_rvalid_needs_txn: assert property (@(posedge clk) disable iff (!rst_n)
        instr_rvalid_i |-> (out_cnt_q != '0));

    // Outstanding count stays within the transaction credit
    a_out_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        32'(out_cnt_q) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_cv32e40p_fetch_req_ctrl.sv
// Directed testbench for cv32e40p_fetch_req_ctrl.
// Per-cycle input vectors with hand-computed output expectations.
module tb_cv32e40p_fetch_req_ctrl;

    localparam int unsigned FD = 2;
    localparam int unsigned MO = 2;

    typedef struct packed {
        logic        rq;
        logic        br;
        logic [31:0] ba;
        logic        hw;
        logic [31:0] ha;
        logic [1:0]  fc;
        logic        g;
        logic        rv;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        push;
        logic        flush;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_addr_i = '0;
    logic        hwlp_jump_i = 1'b0;
    logic [31:0] hwlp_target_i = '0;
    logic [1:0]  fifo_cnt_i = '0;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        fifo_push_o;
    logic        fifo_flush_o;
    logic        busy_o;

    int n_run  = 0;
    int n_fail = 0;

    cv32e40p_fetch_req_ctrl #(
        .FIFO_DEPTH     (FD),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .hwlp_jump_i   (hwlp_jump_i),
        .hwlp_target_i (hwlp_target_i),
        .fifo_cnt_i    (fifo_cnt_i),
        .instr_gnt_i   (instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_req_o   (instr_req_o),
        .instr_addr_o  (instr_addr_o),
        .fifo_push_o   (fifo_push_o),
        .fifo_flush_o  (fifo_flush_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t S(logic rq, logic br, logic [31:0] ba,
                                logic hw, logic [31:0] ha, logic [1:0] fc,
                                logic g, logic rv);
        return {rq, br, ba, hw, ha, fc, g, rv};
    endfunction

    function automatic exp_t E(logic rq, logic [31:0] a, logic p,
                               logic f, logic b);
        return {rq, a, p, f, b};
    endfunction

    function automatic exp_t obs();
        return {instr_req_o, instr_addr_o, fifo_push_o, fifo_flush_o, busy_o};
    endfunction

    task automatic apply(input stim_t v);
        req_i          = v.rq;
        branch_i       = v.br;
        branch_addr_i  = v.ba;
        hwlp_jump_i    = v.hw;
        hwlp_target_i  = v.ha;
        fifo_cnt_i     = v.fc;
        instr_gnt_i    = v.g;
        instr_rvalid_i = v.rv;
    endtask

    task automatic do_reset();
        apply('0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply('0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_run++;
        if (obs() !== E(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset got %h exp %h", obs(), E(0, 0, 0, 0, 0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fill();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 1, 32'h80, 0, 0, 0, 0, 0)); e.push_back(E(0, 32'h0, 0, 1, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));      e.push_back(E(1, 32'h80, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));      e.push_back(E(1, 32'h84, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));      e.push_back(E(0, 32'h88, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));      e.push_back(E(0, 32'h88, 1, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));      e.push_back(E(1, 32'h88, 1, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 1, 0));      e.push_back(E(1, 32'h88, 0, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 1));      e.push_back(E(0, 32'h8C, 1, 0, 1));
        s.push_back(S(0, 0, 0, 0, 0, 0, 0, 0));      e.push_back(E(0, 32'h8C, 0, 0, 0));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL seq_fill[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_flush();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 1, 32'h80, 0, 0, 0, 0, 0));  e.push_back(E(0, 32'h0, 0, 1, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));       e.push_back(E(1, 32'h80, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));       e.push_back(E(1, 32'h84, 0, 0, 1));
        s.push_back(S(1, 1, 32'h200, 0, 0, 0, 0, 0)); e.push_back(E(0, 32'h200, 0, 1, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(0, 32'h200, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(1, 32'h200, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));       e.push_back(E(1, 32'h200, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(1, 32'h204, 1, 0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL branch_flush[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_obi_stability();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 1, 32'h80, 0, 0, 0, 0, 0));  e.push_back(E(0, 32'h0, 0, 1, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));       e.push_back(E(1, 32'h80, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));       e.push_back(E(1, 32'h84, 0, 0, 1));
        s.push_back(S(1, 1, 32'h300, 0, 0, 0, 0, 0)); e.push_back(E(1, 32'h84, 0, 1, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(1, 32'h84, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));       e.push_back(E(1, 32'h84, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 1));       e.push_back(E(1, 32'h300, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(1, 32'h304, 1, 0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL obi_stability[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_priority();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));                  e.push_back(E(0, 32'h0, 0, 0, 0));
        s.push_back(S(1, 1, 32'h400, 1, 32'h500, 0, 1, 0));     e.push_back(E(1, 32'h400, 0, 1, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));                  e.push_back(E(1, 32'h404, 0, 0, 1));
        s.push_back(S(1, 0, 0, 1, 32'h502, 0, 0, 0));            e.push_back(E(1, 32'h404, 0, 1, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));                  e.push_back(E(1, 32'h404, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));                  e.push_back(E(0, 32'h500, 0, 0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL priority[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wrap_credit();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0)); e.push_back(E(0, 32'h0, 0, 1, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));             e.push_back(E(1, 32'hFFFF_FFFC, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));             e.push_back(E(1, 32'h0, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 0));             e.push_back(E(1, 32'h0, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));             e.push_back(E(0, 32'h4, 1, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 1, 0, 1));             e.push_back(E(0, 32'h4, 1, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 2, 0, 0));             e.push_back(E(0, 32'h4, 0, 0, 0));
        s.push_back(S(1, 0, 0, 0, 0, 1, 0, 0));             e.push_back(E(1, 32'h4, 0, 0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL wrap_credit[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_redirect_granted();
        stim_t s[$];
        exp_t  e[$];
        do_reset();
        s.push_back(S(1, 1, 32'h80, 0, 0, 0, 0, 0));  e.push_back(E(0, 32'h0, 0, 1, 0));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 0));       e.push_back(E(1, 32'h80, 0, 0, 1));
        s.push_back(S(1, 1, 32'h600, 0, 0, 0, 1, 0)); e.push_back(E(1, 32'h80, 0, 1, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 1, 1));       e.push_back(E(1, 32'h600, 0, 0, 1));
        s.push_back(S(1, 0, 0, 0, 0, 0, 0, 1));       e.push_back(E(1, 32'h604, 1, 0, 1));
        foreach (s[i]) begin
            apply(s[i]);
            #2;
            n_run++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL redirect_granted[%0d] got %h exp %h", i, obs(), e[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        apply(S(1, 1, 32'h80, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        apply(S(1, 0, 0, 0, 0, 0, 1, 0));
        @(posedge clk);
        #1;
        apply('0);
        #1;
        n_run++;
        if (obs() !== E(0, 32'h84, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL reset_mid_pre got %h exp %h", obs(), E(0, 32'h84, 0, 0, 1));
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if (obs() !== E(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_async got %h exp %h", obs(), E(0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(S(1, 0, 0, 0, 0, 0, 0, 0));
        #2;
        n_run++;
        if (obs() !== E(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_mid_idle got %h exp %h", obs(), E(0, 0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        n_run++;
        if (obs() !== E(1, 0, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL reset_mid_run got %h exp %h", obs(), E(1, 0, 0, 0, 1));
        end
        apply('0);
    endtask

    initial begin
        test_reset();
        test_seq_fill();
        test_branch_flush();
        test_obi_stability();
        test_priority();
        test_wrap_credit();
        test_redirect_granted();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
